// File: rtl/pixel_window_packer.sv
// pixel_window_packer: scans an RGB image ROM in step with the VGA counters and
// produces a zero-padded 3x3 gray neighbourhood plus the centre RGB, three
// cycles after the fetch, aligned to the consumer's hc/vc.
module pixel_window_packer #(
    parameter int X0     = 100,
    parameter int Y0     = 100,
    parameter int IMG_W  = 160,
    parameter int IMG_H  = 115,
    parameter int ADDR_W = 15
) (
    input  logic              pixel_clk,
    input  logic              reset,
    input  logic              blank,
    input  logic [9:0]        hc,
    input  logic [9:0]        vc,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [23:0]       rom_data,
    output logic [95:0]       dout,
    output logic              dout_valid
);

    localparam int unsigned LB_DEPTH = IMG_W + 2;
    localparam int unsigned IDX_W    = $clog2(LB_DEPTH);

    // fetch-side decode
    int                fx_c;
    int                fy_c;
    logic              fetch_act_c;
    logic              in_img_c;
    logic              out_ok_c;
    logic [ADDR_W-1:0] addr_c;
    logic [IDX_W-1:0]  idx_c;

    // S0 registers
    logic [ADDR_W-1:0] rom_addr_q;
    logic [IDX_W-1:0]  idx_s0_q;
    logic              pad_s0_q;
    logic              act_s0_q;
    logic              vld_s0_q;

    // S1 pixel entering the window pipe
    logic [9:0]        gray_sum_c;
    logic [7:0]        gray_c;
    logic [23:0]       rgb_c;

    // line buffers: lb1 = {gray, rgb} of row fy-1, lb2 = gray of row fy-2
    logic [31:0]       lb1_q [LB_DEPTH];
    logic [7:0]        lb2_q [LB_DEPTH];
    logic [31:0]       lb1_rd_c;
    logic [7:0]        lb2_rd_c;

    // S2 column shift registers, index 0 is the newest (rightmost) column
    logic [2:0][7:0]   top_q;
    logic [2:0][7:0]   mid_q;
    logic [2:0][7:0]   bot_q;
    logic [2:0][23:0]  rgb_col_q;
    logic              vld_s2_q;

    // S3 outputs
    logic [95:0]       dout_q;
    logic              dout_valid_q;

    // Decode fetch coordinates from the live counters
    always_comb begin
        fx_c        = int'(hc) - X0 + 4;
        fy_c        = int'(vc) - Y0 + 1;
        fetch_act_c = !blank && (fx_c >= -1) && (fx_c <= IMG_W)
                             && (fy_c >= -1) && (fy_c <= IMG_H);
        in_img_c    = fetch_act_c && (fx_c >= 0) && (fx_c < IMG_W)
                                  && (fy_c >= 0) && (fy_c < IMG_H);
        // window centre (fx-1, fy-1) lies inside the image
        out_ok_c    = !blank && (fx_c >= 1) && (fx_c <= IMG_W)
                             && (fy_c >= 1) && (fy_c <= IMG_H);
        addr_c      = ADDR_W'(fy_c * IMG_W + fx_c);
        idx_c       = IDX_W'(fx_c + 1);
    end

    // S0: issue ROM address and register fetch flags
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            rom_addr_q <= '0;
            idx_s0_q   <= '0;
            pad_s0_q   <= 1'b0;
            act_s0_q   <= 1'b0;
            vld_s0_q   <= 1'b0;
        end else begin
            if (in_img_c) begin
                rom_addr_q <= addr_c;
            end
            if (fetch_act_c) begin
                idx_s0_q <= idx_c;
            end
            pad_s0_q <= !in_img_c;
            act_s0_q <= fetch_act_c;
            vld_s0_q <= out_ok_c;
        end
    end

    // S1: gray conversion of the returned ROM word, zeroed for padding
    always_comb begin
        gray_sum_c = 10'(rom_data[7:0]) + 10'({rom_data[15:8], 1'b0}) + 10'(rom_data[23:16]);
        gray_c     = pad_s0_q ? 8'd0  : gray_sum_c[9:2];
        rgb_c      = pad_s0_q ? 24'd0 : rom_data;
        lb1_rd_c   = lb1_q[idx_s0_q];
        lb2_rd_c   = lb2_q[idx_s0_q];
    end

    // S2: line buffers age one row per visit; contents are refreshed by padding rows
    always_ff @(posedge pixel_clk) begin
        if (act_s0_q) begin
            lb2_q[idx_s0_q] <= lb1_rd_c[31:24];
            lb1_q[idx_s0_q] <= {gray_c, rgb_c};
        end
    end

    // S2: shift the three rows of the window by one column
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            top_q     <= '0;
            mid_q     <= '0;
            bot_q     <= '0;
            rgb_col_q <= '0;
            vld_s2_q  <= 1'b0;
        end else begin
            if (act_s0_q) begin
                top_q     <= {top_q[1:0], lb2_rd_c};
                mid_q     <= {mid_q[1:0], lb1_rd_c[31:24]};
                bot_q     <= {bot_q[1:0], gray_c};
                rgb_col_q <= {rgb_col_q[1:0], lb1_rd_c[23:0]};
            end
            vld_s2_q <= vld_s0_q;
        end
    end

    // S3: pack the window around the middle column
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            dout_valid_q <= vld_s2_q;
            if (vld_s2_q) begin
                dout_q <= {mid_q[1], mid_q[2], mid_q[0], top_q[1], bot_q[1],
                           top_q[2], bot_q[2], top_q[0], bot_q[0], rgb_col_q[1]};
            end else begin
                dout_q <= '0;
            end
        end
    end

    assign rom_addr   = rom_addr_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;

endmodule
